// File: rtl/package_increment_stage.sv
// package_increment_stage
// Registered valid/ready stage that adds INC to each WIDTH-bit operand.
// The 2-entry skid buffer gives full throughput with a registered o_ready.
// Also reports the carry-out of each addition and counts delivered results.

module package_increment_stage #(
    parameter int WIDTH = 10,
    parameter int INC   = 1,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_wrap,
    output logic [CNT_W-1:0] o_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // The increment is widened by one bit so the carry-out lands in the top bit.
    localparam logic [WIDTH:0] INC_EXT = (WIDTH+1)'(INC);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_wrap_q, out_wrap_d;
    logic [WIDTH-1:0]   skid_data_q, skid_data_d;
    logic               skid_wrap_q, skid_wrap_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               push;
    logic               pop;
    logic [WIDTH:0]     sum;

    assign push = i_valid && ready_q;
    assign pop  = (state_q != EMPTY) && i_ready;
    assign sum  = {1'b0, i_data} + INC_EXT;

    // Next-state logic: route the new result into OUT or SKID and track occupancy.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_wrap_d  = out_wrap_q;
        skid_data_d = skid_data_q;
        skid_wrap_d = skid_wrap_q;
        count_d     = count_q;

        if (pop) begin
            count_d = count_q + CNT_W'(1);
        end

        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d    = ONE;
                    out_data_d = sum[WIDTH-1:0];
                    out_wrap_d = sum[WIDTH];
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d     = TWO;
                    skid_data_d = sum[WIDTH-1:0];
                    skid_wrap_d = sum[WIDTH];
                end else if (push && pop) begin
                    state_d    = ONE;
                    out_data_d = sum[WIDTH-1:0];
                    out_wrap_d = sum[WIDTH];
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d    = ONE;
                    out_data_d = skid_data_q;
                    out_wrap_d = skid_wrap_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Ready only looks at the upcoming occupancy, never at i_ready directly.
        ready_d = (state_d != TWO);
    end

    // State, storage, ready and counter registers; reset discards buffered results.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            out_wrap_q  <= 1'b0;
            skid_data_q <= '0;
            skid_wrap_q <= 1'b0;
            ready_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_wrap_q  <= out_wrap_d;
            skid_data_q <= skid_data_d;
            skid_wrap_q <= skid_wrap_d;
            ready_q     <= ready_d;
            count_q     <= count_d;
        end
    end

    assign o_valid = (state_q != EMPTY);
    assign o_ready = ready_q;
    assign o_data  = out_data_q;
    assign o_wrap  = out_wrap_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_package_increment_stage.sv
// tb_package_increment_stage
// Directed scenarios plus a random valid/ready phase, all compared against a
// queue-based reference of the increment stage.

module tb_package_increment_stage;

    localparam int WIDTH = 10;
    localparam int INC   = 1;
    localparam int CNT_W = 16;
    localparam int MODW  = 1 << WIDTH;
    localparam int MODC  = 1 << CNT_W;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_data;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_data;
    logic             o_wrap;
    logic [CNT_W-1:0] o_count;

    int checkCount = 0;
    int errorCount = 0;

    // Reference: queue of full (unwrapped) sums, at most two deep.
    int modelQ[$];
    bit modelReady;
    int modelCount;

    package_increment_stage #(
        .WIDTH(WIDTH),
        .INC  (INC),
        .CNT_W(CNT_W)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_data (i_data),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_data (o_data),
        .o_wrap (o_wrap),
        .o_count(o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit v, input int d, input bit r);
        i_valid = v;
        i_data  = WIDTH'(d);
        i_ready = r;
    endtask

    task automatic modelClear();
        modelQ.delete();
        modelReady = 1'b0;
        modelCount = 0;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_valid"}, 32'(o_valid), 32'(modelQ.size() > 0));
        checkOutput({tag, "_ready"}, 32'(o_ready), 32'(modelReady));
        checkOutput({tag, "_count"}, 32'(o_count), 32'(modelCount));
        if (modelQ.size() > 0) begin
            checkOutput({tag, "_data"}, 32'(o_data), 32'(modelQ[0] % MODW));
            checkOutput({tag, "_wrap"}, 32'(o_wrap), 32'(modelQ[0] >= MODW));
        end
    endtask

    // One clock: update the reference at the rising edge, compare at the falling edge.
    task automatic stepCycle(input string tag);
        bit pushM;
        bit popM;
        @(posedge i_clk);
        if (!i_rst_n) begin
            modelClear();
        end else begin
            pushM = i_valid && modelReady;
            popM  = (modelQ.size() > 0) && i_ready;
            if (popM) begin
                void'(modelQ.pop_front());
                modelCount = (modelCount + 1) % MODC;
            end
            if (pushM) modelQ.push_back(int'(i_data) + INC);
            modelReady = (modelQ.size() < 2);
        end
        @(negedge i_clk);
        checkModel(tag);
    endtask

    // Asynchronous reset pulse between edges, then release and see o_ready rise.
    task automatic doReset(input string tag);
        #2;
        i_rst_n = 1'b0;
        #1;
        modelClear();
        checkOutput({tag, "_rst_valid"}, 32'(o_valid), 32'd0);
        checkOutput({tag, "_rst_ready"}, 32'(o_ready), 32'd0);
        checkOutput({tag, "_rst_data"},  32'(o_data),  32'd0);
        checkOutput({tag, "_rst_wrap"},  32'(o_wrap),  32'd0);
        checkOutput({tag, "_rst_count"}, 32'(o_count), 32'd0);
        applyStimulus(1'b1, int'($urandom_range(0, MODW - 1)), 1'b1);
        stepCycle({tag, "_inrst"});
        applyStimulus(1'b0, 0, 1'b1);
        i_rst_n = 1'b1;
        #1;
        checkOutput({tag, "_rel_ready0"}, 32'(o_ready), 32'd0);
        stepCycle({tag, "_rel"});
        checkOutput({tag, "_rel_ready1"}, 32'(o_ready), 32'd1);
    endtask

    initial begin
        i_rst_n = 1'b0;
        modelClear();
        applyStimulus(1'b0, 0, 1'b0);

        // Reset values with random inputs applied
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom), int'($urandom_range(0, MODW - 1)), 1'($urandom));
            stepCycle("reset_hold");
            checkOutput("reset_valid", 32'(o_valid), 32'd0);
            checkOutput("reset_ready", 32'(o_ready), 32'd0);
            checkOutput("reset_data",  32'(o_data),  32'd0);
            checkOutput("reset_wrap",  32'(o_wrap),  32'd0);
            checkOutput("reset_count", 32'(o_count), 32'd0);
        end
        applyStimulus(1'b0, 0, 1'b1);
        i_rst_n = 1'b1;
        stepCycle("release");
        checkOutput("release_ready", 32'(o_ready), 32'd1);

        // Single transfer
        applyStimulus(1'b1, 'h005, 1'b1);
        stepCycle("single");
        checkOutput("single_data",  32'(o_data),  32'h006);
        checkOutput("single_wrap",  32'(o_wrap),  32'd0);
        checkOutput("single_valid", 32'(o_valid), 32'd1);
        applyStimulus(1'b0, 0, 1'b1);
        stepCycle("single_pop");
        checkOutput("single_count", 32'(o_count), 32'd1);

        // Wrap boundary
        applyStimulus(1'b1, 'h3FF, 1'b1);
        stepCycle("wrap");
        checkOutput("wrap_data", 32'(o_data), 32'h000);
        checkOutput("wrap_flag", 32'(o_wrap), 32'd1);
        applyStimulus(1'b1, 'h3FE, 1'b1);
        stepCycle("nowrap");
        checkOutput("nowrap_data", 32'(o_data), 32'h3FF);
        checkOutput("nowrap_flag", 32'(o_wrap), 32'd0);
        applyStimulus(1'b0, 0, 1'b1);
        stepCycle("wrap_drain");

        // Back-pressure fills the skid buffer
        doReset("bp");
        applyStimulus(1'b1, 1, 1'b0);
        stepCycle("bp_push1");
        checkOutput("bp_ready1", 32'(o_ready), 32'd1);
        applyStimulus(1'b1, 2, 1'b0);
        stepCycle("bp_push2");
        checkOutput("bp_ready2", 32'(o_ready), 32'd0);
        applyStimulus(1'b1, 3, 1'b0);
        stepCycle("bp_hold");
        checkOutput("bp_hold_data", 32'(o_data), 32'd2);
        applyStimulus(1'b1, 3, 1'b1);
        stepCycle("bp_pop1");
        checkOutput("bp_out3", 32'(o_data), 32'd3);
        applyStimulus(1'b1, 3, 1'b1);
        stepCycle("bp_pop2");
        checkOutput("bp_out4", 32'(o_data), 32'd4);
        applyStimulus(1'b0, 0, 1'b1);
        stepCycle("bp_pop3");
        checkOutput("bp_count", 32'(o_count), 32'd3);
        checkOutput("bp_empty", 32'(o_valid), 32'd0);

        // Streaming at full rate
        doReset("stream");
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, i, 1'b1);
            stepCycle("stream");
            checkOutput("stream_data",  32'(o_data),  32'(i + 1));
            checkOutput("stream_ready", 32'(o_ready), 32'd1);
        end
        applyStimulus(1'b0, 0, 1'b1);
        stepCycle("stream_end");
        checkOutput("stream_count", 32'(o_count), 32'd100);

        // Reset while the skid buffer is full
        doReset("mid_pre");
        applyStimulus(1'b1, 7, 1'b0);
        stepCycle("mid_fill1");
        applyStimulus(1'b1, 8, 1'b0);
        stepCycle("mid_fill2");
        checkOutput("mid_two_ready", 32'(o_ready), 32'd0);
        doReset("mid");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 0, 1'b1);
            stepCycle("mid_after");
            checkOutput("mid_no_stale", 32'(o_valid), 32'd0);
        end
        checkOutput("mid_count", 32'(o_count), 32'd0);

        // Random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), int'($urandom_range(0, MODW - 1)),
                          ($urandom_range(0, 2) != 0));
            stepCycle("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
